// File: rtl/waveform_pkg.sv
// Shared waveform-mode encodings and LFSR constants for the DDS waveform source.
package waveform_pkg;

  localparam logic [1:0] MODE_SQUARE = 2'd0;
  localparam logic [1:0] MODE_SAW    = 2'd1;
  localparam logic [1:0] MODE_TRI    = 2'd2;
  localparam logic [1:0] MODE_NOISE  = 2'd3;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

endpackage

// File: rtl/lfsr_16.sv
// 16-bit Galois right-shift LFSR; advances once per step, exposes the top OUT_W bits of the next state.
// Latency: the next value is combinational so the caller can register it on the same edge as the step.
module lfsr_16
  import waveform_pkg::*;
#(
  parameter int OUT_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  output logic [OUT_W-1:0] nxt_top
);

  logic [15:0] state;
  logic [15:0] nxt;

  // Seed is non-zero and the mask keeps it that way, so the lock-up state never occurs.
  assign nxt = state[0] ? ((state >> 1) ^ LFSR_MASK) : (state >> 1);
  assign nxt_top = nxt[15 -: OUT_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= LFSR_SEED;
    end else if (step) begin
      state <= nxt;
    end
  end

endmodule

// File: rtl/dds_waveform_gen.sv
// Phase-accumulator square/saw/triangle/noise source; one sample per DIV-cycle tick, valid 1 cycle after the tick.
// Ticks arriving while a sample is unaccepted are dropped and flag sticky overrun; AMPLITUDE_SCALE_EN adds atten.
module dds_waveform_gen
  import waveform_pkg::*;
#(
  parameter int DATA_W  = 12,
  parameter int PHASE_W = 16,
  parameter int DIV     = 2500
) (
  input  logic               qzt_clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [1:0]         mode,
  input  logic [PHASE_W-1:0] freq_word,
`ifdef AMPLITUDE_SCALE_EN
  input  logic [1:0]         atten,
`endif
  input  logic               dac_ready,
  output logic               dac_valid,
  output logic [DATA_W-1:0]  Va,
  output logic [DATA_W-1:0]  Vb,
  output logic               overrun
);

  localparam int M     = PHASE_W - 1;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0]   count;
  logic               tick;
  logic               accept;
  logic [PHASE_W-1:0] acc;
  logic [PHASE_W-1:0] acc_next;
  logic [DATA_W-1:0]  noise_code;
  logic [DATA_W-1:0]  wave;
  logic [DATA_W-1:0]  wave_scaled;

  assign tick     = enable && (count == CNT_LAST);
  assign accept   = tick && (!dac_valid || dac_ready);
  assign acc_next = acc + freq_word;

  always_ff @(posedge qzt_clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!enable || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  lfsr_16 #(
    .OUT_W (DATA_W)
  ) u_lfsr (
    .clk     (qzt_clk),
    .reset   (reset),
    .step    (accept),
    .nxt_top (noise_code)
  );

  // Code is derived from the post-update phase so the registered Va matches the new accumulator.
  always_comb begin
    wave = '0;
    case (mode)
      MODE_SQUARE: wave = {DATA_W{acc_next[M]}};
      MODE_SAW:    wave = acc_next[M -: DATA_W];
      MODE_TRI:    wave = acc_next[M] ? ~acc_next[M-1 -: DATA_W] : acc_next[M-1 -: DATA_W];
      default:     wave = noise_code;
    endcase
  end

`ifdef AMPLITUDE_SCALE_EN
  assign wave_scaled = wave >> atten;
`else
  assign wave_scaled = wave;
`endif

  always_ff @(posedge qzt_clk or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      Va        <= '0;
      dac_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (accept) begin
        acc       <= acc_next;
        Va        <= wave_scaled;
        dac_valid <= 1'b1;
      end else if (dac_valid && dac_ready) begin
        dac_valid <= 1'b0;
      end
      if (tick && dac_valid && !dac_ready) begin
        overrun <= 1'b1;
      end
    end
  end

  assign Vb = ~Va;

endmodule

// File: tb/tb_dds_waveform_gen.sv
// Directed bench for dds_waveform_gen with DIV=4: reset, saw, triangle, backpressure, noise, square/async reset.
module tb_dds_waveform_gen;
  import waveform_pkg::*;

  localparam int DATA_W  = 12;
  localparam int PHASE_W = 16;
  localparam int DIV     = 4;

  logic               qzt_clk   = 1'b0;
  logic               reset     = 1'b1;
  logic               enable    = 1'b0;
  logic [1:0]         mode      = 2'd0;
  logic [PHASE_W-1:0] freq_word = '0;
  logic               dac_ready = 1'b0;
  logic               dac_valid;
  logic [DATA_W-1:0]  Va;
  logic [DATA_W-1:0]  Vb;
  logic               overrun;
`ifdef AMPLITUDE_SCALE_EN
  logic [1:0]         atten = 2'd0;
  localparam logic [DATA_W-1:0] SQ_HI = 12'h3FF;
`else
  localparam logic [DATA_W-1:0] SQ_HI = 12'hFFF;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 qzt_clk = ~qzt_clk;

  dds_waveform_gen #(
    .DATA_W  (DATA_W),
    .PHASE_W (PHASE_W),
    .DIV     (DIV)
  ) dut (
    .qzt_clk   (qzt_clk),
    .reset     (reset),
    .enable    (enable),
    .mode      (mode),
    .freq_word (freq_word),
`ifdef AMPLITUDE_SCALE_EN
    .atten     (atten),
`endif
    .dac_ready (dac_ready),
    .dac_valid (dac_valid),
    .Va        (Va),
    .Vb        (Vb),
    .overrun   (overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    enable    = 1'b0;
    dac_ready = 1'b0;
    @(negedge qzt_clk);
    @(negedge qzt_clk);
    reset = 1'b0;
  endtask

  // Returns negedges elapsed until dac_valid is seen (64 means the bound expired).
  task automatic wait_sample(output int n);
    @(negedge qzt_clk);
    n = 1;
    while (!dac_valid && n < 64) begin
      @(negedge qzt_clk);
      n++;
    end
  endtask

  logic [DATA_W-1:0] saw_exp [16] = '{12'h100, 12'h200, 12'h300, 12'h400, 12'h500, 12'h600,
                                      12'h700, 12'h800, 12'h900, 12'hA00, 12'hB00, 12'hC00,
                                      12'hD00, 12'hE00, 12'hF00, 12'h000};
  logic [DATA_W-1:0] tri_exp [8]  = '{12'h400, 12'h800, 12'hC00, 12'hFFF,
                                      12'hBFF, 12'h7FF, 12'h3FF, 12'h000};

  initial begin
    int n;
    logic [15:0] l;

    // 1: reset state
    do_reset();
    chk("rst_valid", dac_valid, 0);
    chk("rst_va", Va, 12'h000);
    chk("rst_vb", Vb, 12'hFFF);
    chk("rst_overrun", overrun, 0);

    // 2: sawtooth, one-cycle valid pulses every DIV cycles
    mode = MODE_SAW; freq_word = 16'h1000; dac_ready = 1'b1; enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wait_sample(n);
      chk($sformatf("saw_interval[%0d]", i), n, DIV);
      chk($sformatf("saw_va[%0d]", i), Va, saw_exp[i]);
      if (i == 3) chk("saw_vb3", Vb, 12'hBFF);
    end

    // 3: triangle, two periods
    do_reset();
    mode = MODE_TRI; freq_word = 16'h2000; dac_ready = 1'b1; enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wait_sample(n);
      chk($sformatf("tri_va[%0d]", i), Va, tri_exp[i % 8]);
    end

    // 4: backpressure drops ticks, holds Va, sets sticky overrun
    do_reset();
    mode = MODE_SAW; freq_word = 16'h1000; dac_ready = 1'b1; enable = 1'b1;
    wait_sample(n);
    chk("bp_first", Va, 12'h100);
    dac_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge qzt_clk);
      if (i == 5) chk("bp_hold_mid", Va, 12'h100);
    end
    chk("bp_hold_va", Va, 12'h100);
    chk("bp_hold_valid", dac_valid, 1);
    chk("bp_overrun", overrun, 1);
    dac_ready = 1'b1;
    @(negedge qzt_clk);
    chk("bp_xfer_valid", dac_valid, 0);
    wait_sample(n);
    chk("bp_next_va", Va, 12'h200);
    chk("bp_overrun_sticky", overrun, 1);

    // 5: noise against a mask model
    do_reset();
    mode = MODE_NOISE; freq_word = 16'h0123; dac_ready = 1'b1; enable = 1'b1;
    l = LFSR_SEED;
    for (int i = 0; i < 8; i++) begin
      wait_sample(n);
      l = l[0] ? ((l >> 1) ^ LFSR_MASK) : (l >> 1);
      if (i == 0) chk("noise_first", Va, 12'hE27);
      chk($sformatf("noise_va[%0d]", i), Va, l[15:4]);
    end

    // 6: square, then async reset while a sample is pending
    do_reset();
`ifdef AMPLITUDE_SCALE_EN
    atten = 2'd2;
`endif
    mode = MODE_SQUARE; freq_word = 16'h8000; dac_ready = 1'b1; enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_sample(n);
      chk($sformatf("sq_va[%0d]", i), Va, (i % 2 == 0) ? SQ_HI : 12'h000);
    end
    wait_sample(n);
    dac_ready = 1'b0;
    chk("sq_pending", dac_valid, 1);
    chk("sq_pending_va", Va, SQ_HI);
    reset = 1'b1;
    #1;
    chk("async_rst_valid", dac_valid, 0);
    chk("async_rst_va", Va, 12'h000);
    chk("async_rst_vb", Vb, 12'hFFF);
    @(negedge qzt_clk);
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
